// File: rtl/adders_tree_sequencer.sv
// Four-operand adder tree (a+b, c+d, sum of both) evaluated over three cycles
// on a single shared adder, with valid/ready handshakes on both sides.
module adders_tree_sequencer #(
    parameter int unsigned A_W   = 4,
    parameter int unsigned C_W   = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    input  logic [C_W-1:0]   d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [A_W:0]     sum1,
    output logic [C_W:0]     sum2,
    output logic [C_W+1:0]   sum3,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned S_W = C_W + 2;

    typedef enum logic [2:0] {
        StIdle,
        StAdd1,
        StAdd2,
        StAdd3,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [A_W-1:0] a_q, b_q;
    logic [C_W-1:0] c_q, d_q;
    logic [S_W-1:0] add_x, add_y, add_res;
    logic           accept, consume;

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready  = rst_n && (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign add_res   = add_x + add_y;

    always_comb begin
        state_d = state_q;
        add_x   = '0;
        add_y   = '0;
        unique case (state_q)
            StIdle: if (accept) state_d = StAdd1;
            StAdd1: begin
                add_x   = S_W'(a_q);
                add_y   = S_W'(b_q);
                state_d = StAdd2;
            end
            StAdd2: begin
                add_x   = S_W'(c_q);
                add_y   = S_W'(d_q);
                state_d = StAdd3;
            end
            StAdd3: begin
                add_x   = S_W'(sum1);
                add_y   = S_W'(sum2);
                state_d = StDone;
            end
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            sum1     <= '0;
            sum2     <= '0;
            sum3     <= '0;
            op_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= a;
                b_q <= b;
                c_q <= c;
                d_q <= d;
            end
            if (state_q == StAdd1) sum1 <= add_res[A_W:0];
            if (state_q == StAdd2) sum2 <= add_res[C_W:0];
            if (state_q == StAdd3) sum3 <= add_res;
            if (consume) op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adders_tree_sequencer.sv
// Randomised bench for adders_tree_sequencer: directed cases, random operands,
// back-pressure and busy-time noise, checked against plain integer arithmetic.
module tb_adders_tree_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready;
    logic       in_ready, out_valid, busy;
    logic [3:0] a, b;
    logic [7:0] c, d;
    logic [4:0] sum1;
    logic [8:0] sum2;
    logic [9:0] sum3;
    logic [7:0] op_count;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_count = 0;
    int cyc       = 0;
    int last_acc  = -1;

    adders_tree_sequencer #(.A_W(4), .C_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum1      (sum1),
        .sum2      (sum2),
        .sum3      (sum3),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_noise();
        in_valid = 1'b1;
        a = 4'($urandom);
        b = 4'($urandom);
        c = 8'($urandom);
        d = 8'($urandom);
    endtask

    // One full transaction; expected sums are plain integer arithmetic on the operands.
    task automatic run_op(input int ai, input int bi, input int ci, input int di,
                          input int hold, input bit noise, input bit chk_ii);
        int n, e1, e2, e3, acc;
        logic [31:0] av, bv, cv, dv;
        e1 = ai + bi;
        e2 = ci + di;
        e3 = e1 + e2;
        av = ai; bv = bi; cv = ci; dv = di;
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a = av[3:0];
        b = bv[3:0];
        c = cv[7:0];
        d = dv[7:0];
        @(posedge clk); #1;
        acc = cyc;
        if (chk_ii && last_acc >= 0) check("ii", acc - last_acc, 5);
        last_acc = acc;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            if (noise) drive_noise();
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 4);
        check("out_valid", out_valid, 1);
        for (int i = 0; i < hold; i++) begin
            if (noise) drive_noise();
            check("in_ready_busy", in_ready, 0);
            @(posedge clk); #1;
            check("out_valid_hold", out_valid, 1);
            check("sum3_hold", sum3, e3);
        end
        check("sum1", sum1, e1);
        check("sum2", sum2, e2);
        check("sum3", sum3, e3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_count = (exp_count + 1) % 256;
        check("op_count", op_count, exp_count);
        check("out_valid_drop", out_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum1", sum1, 0);
        check("rst_sum2", sum2, 0);
        check("rst_sum3", sum3, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_op_count", op_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        do_reset();

        run_op(0, 3, 1, 255, 0, 1'b0, 1'b0);
        run_op(15, 15, 255, 255, 0, 1'b0, 1'b0);
        run_op(10, 13, 9, 10, 6, 1'b0, 1'b0);
        run_op(15, 15, 109, 37, 3, 1'b1, 1'b0);

        // Abort during ADD2: sum1 already holds a result, reset must clear it.
        in_valid = 1'b1; a = 4'd5; b = 4'd6; c = 8'd7; d = 8'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_add2", busy, 1);
        check("sum1_add2", sum1, 11);
        do_reset();
        run_op(0, 9, 45, 45, 0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++)
            run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 3), 1'($urandom), 1'b0);

        do_reset();
        last_acc = -1;
        for (int k = 0; k < 256; k++)
            run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
                   $urandom_range(0, 255), 0, 1'b0, 1'b1);
        check("op_count_wrap", op_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
